// File: rtl/tinyriscv_pkg.sv
// Shared types and constants for the tinyriscv pipeline control logic.
// Contents:
//   RegAddrW, NumRegs : GPR address width and register count
//   FlushCntW         : width of the post-jump flush down-counter
//   ctrl_state_e      : hazard controller state encoding (debug-visible)
//   reg_hit()         : non-x0 destination matches either decode source
package tinyriscv_pkg;

  localparam int RegAddrW  = 5;
  localparam int NumRegs   = 32;
  localparam int FlushCntW = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_BUSY = 2'd1,
    FLUSH    = 2'd2,
    BUS_WAIT = 2'd3
  } ctrl_state_e;

  // x0 is never a real dependency, so a zero destination never matches.
  function automatic logic reg_hit(input logic [RegAddrW-1:0] rd,
                                   input logic [RegAddrW-1:0] rs1,
                                   input logic [RegAddrW-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: one pending bit per GPR for loads still in flight.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   set_en, set_addr      : mark a register pending (load issued)
//   clr_en, clr_addr      : clear a register (load data written back)
//   rd1_addr/rd1_pending  : combinational lookup port 1
//   rd2_addr/rd2_pending  : combinational lookup port 2
// A set and clear of the same register in one cycle leaves it pending,
// because the set belongs to a newer load. Bit 0 (x0) is constant 0.
module hazard_scoreboard
  import tinyriscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [RegAddrW-1:0] set_addr,
  input  logic                clr_en,
  input  logic [RegAddrW-1:0] clr_addr,
  input  logic [RegAddrW-1:0] rd1_addr,
  output logic                rd1_pending,
  input  logic [RegAddrW-1:0] rd2_addr,
  output logic                rd2_pending
);

  logic [NumRegs-1:0] pending;

  assign pending[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NumRegs; gi++) begin : g_bit
      logic bit_reg;
      logic set_hit;
      logic clr_hit;

      assign set_hit = set_en && (set_addr == RegAddrW'(gi));
      assign clr_hit = clr_en && (clr_addr == RegAddrW'(gi));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          bit_reg <= 1'b0;
        end else if (set_hit) begin
          bit_reg <= 1'b1;
        end else if (clr_hit) begin
          bit_reg <= 1'b0;
        end
      end

      assign pending[gi] = bit_reg;
    end
  endgenerate

  assign rd1_pending = pending[rd1_addr];
  assign rd2_pending = pending[rd2_addr];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the IF/ID/EX core.
// Tracks outstanding loads, detects RAW hazards at decode, and sequences
// divide stalls, jump flush windows and bus-arbiter stalls.
// Parameter:
//   FlushCycles (0..7) : extra cycles IF/ID stays flushed after a jump
// Build option:
//   HAZARD_FWD_EN : when defined, EX->ID forwarding exists and only load-use
//                   hazards stall; when undefined, a decode read of any
//                   non-x0 register written by the EX instruction also stalls.
// Ports:
//   clk, rst_n                        : clock, synchronous active-low reset
//   id_valid_i, id_reg{1,2}_raddr_i   : decode instruction and its sources
//   ex_we_i, ex_rd_i, ex_load_i       : EX destination / load issue
//   lsu_rsp_valid_i, lsu_rsp_rd_i     : load write-back
//   div_start_i, div_ready_i          : divider handshake
//   ex_jump_flag_i, bus_hold_i        : taken branch/jump, bus stall
//   hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
//   div_kill_o                        : pipeline controls (combinational)
//   state_o                           : current ctrl_state_e for debug
module hazard_ctrl
  import tinyriscv_pkg::*;
#(
  parameter int FlushCycles = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid_i,
  input  logic [RegAddrW-1:0] id_reg1_raddr_i,
  input  logic [RegAddrW-1:0] id_reg2_raddr_i,
  input  logic                ex_we_i,
  input  logic [RegAddrW-1:0] ex_rd_i,
  input  logic                ex_load_i,
  input  logic                lsu_rsp_valid_i,
  input  logic [RegAddrW-1:0] lsu_rsp_rd_i,
  input  logic                div_start_i,
  input  logic                div_ready_i,
  input  logic                ex_jump_flag_i,
  input  logic                bus_hold_i,
  output logic                hold_pc_o,
  output logic                hold_if_id_o,
  output logic                hold_id_ex_o,
  output logic                flush_if_id_o,
  output logic                flush_id_ex_o,
  output logic                div_kill_o,
  output logic [1:0]          state_o
);

  localparam logic [FlushCntW-1:0] FlushLoad = FlushCntW'(FlushCycles);
  // With no extra flush cycles a jump is fully handled in its own cycle.
  localparam ctrl_state_e JumpState = (FlushCycles > 0) ? FLUSH : RUN;

  ctrl_state_e          state_reg, state_next;
  logic [FlushCntW-1:0] cnt_reg, cnt_next;

  logic rs1_pending, rs2_pending;
  logic ex_rd_hit, load_set, load_use, stall;
  logic hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, div_kill;

  assign load_set  = ex_load_i && ex_we_i && (ex_rd_i != '0);
  assign ex_rd_hit = ex_we_i && reg_hit(ex_rd_i, id_reg1_raddr_i, id_reg2_raddr_i);
  assign load_use  = id_valid_i && (rs1_pending || rs2_pending || (ex_load_i && ex_rd_hit));

`ifdef HAZARD_FWD_EN
  assign stall = load_use;
`else
  assign stall = load_use || (id_valid_i && ex_rd_hit);
`endif

  hazard_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en      (load_set),
    .set_addr    (ex_rd_i),
    .clr_en      (lsu_rsp_valid_i),
    .clr_addr    (lsu_rsp_rd_i),
    .rd1_addr    (id_reg1_raddr_i),
    .rd1_pending (rs1_pending),
    .rd2_addr    (id_reg2_raddr_i),
    .rd2_pending (rs2_pending)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hold_pc     = 1'b0;
    hold_if_id  = 1'b0;
    hold_id_ex  = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    div_kill    = 1'b0;

    unique case (state_reg)
      // BUS_WAIT with the bus released behaves exactly like RUN, so both
      // share one decision tree; only the debug state differs.
      RUN, BUS_WAIT: begin
        if (ex_jump_flag_i) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          cnt_next    = FlushLoad;
          state_next  = JumpState;
        end else if (bus_hold_i) begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
          state_next = BUS_WAIT;
        end else if (div_start_i) begin
          // The divide sits in EX from this cycle on, so hold immediately.
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
          state_next = DIV_BUSY;
        end else begin
          state_next = RUN;
          if (stall) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
          end
        end
      end

      DIV_BUSY: begin
        if (ex_jump_flag_i) begin
          div_kill    = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          cnt_next    = FlushLoad;
          state_next  = JumpState;
        end else if (bus_hold_i) begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
          // Keep tracking the divide until its result is in.
          state_next = div_ready_i ? BUS_WAIT : DIV_BUSY;
        end else if (!div_ready_i) begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
        end else begin
          state_next = RUN;
          if (stall) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
          end
        end
      end

      FLUSH: begin
        if (ex_jump_flag_i) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          cnt_next    = FlushLoad;
          state_next  = JumpState;
        end else begin
          flush_if_id = 1'b1;
          if (cnt_reg <= FlushCntW'(1)) begin
            cnt_next   = '0;
            state_next = RUN;
          end else begin
            cnt_next = cnt_reg - FlushCntW'(1);
          end
        end
      end

      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are forced quiet during reset so a reset in the middle of a
  // divide or flush never produces a stray kill or flush pulse.
  assign hold_pc_o     = rst_n & hold_pc;
  assign hold_if_id_o  = rst_n & hold_if_id;
  assign hold_id_ex_o  = rst_n & hold_id_ex;
  assign flush_if_id_o = rst_n & flush_if_id;
  assign flush_id_ex_o = rst_n & flush_id_ex;
  assign div_kill_o    = rst_n & div_kill;
  assign state_o       = rst_n ? state_reg : RUN;

endmodule
